// File: rtl/apb_slave_regs.sv
// APB3 completer with a NUM_REGS x DATA_W register bank, programmable wait states and error responses.
// Optional byte strobes are enabled with `define APB_SLV_PSTRB_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
// ST_ACCESS | transfer captured; counting wait states, then completing
module apb_slave_regs #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int NB    = DATA_W / 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);
  localparam logic [3:0]        WAIT_LD    = 4'(WAIT_CYCLES);

  logic [0:0]        state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  cap_idx;
  logic              cap_write;
  logic              cap_err;
  logic [DATA_W-1:0] cap_wdata;
  logic [NB-1:0]     cap_strb;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0]  setup_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              addr_ok;
  logic              setup_err;
  logic              rd_strb_err;
  logic [NB-1:0]     strb_in;
  logic              is_setup;
  logic              is_access;
  logic              xfer_done;
  logic              wr_commit;

`ifdef APB_SLV_PSTRB_EN
  assign strb_in     = PSTRB;
  assign rd_strb_err = !PWRITE && (PSTRB != '0);
`else
  assign strb_in     = '1;
  assign rd_strb_err = 1'b0;
`endif

  always_comb begin
    setup_idx = PADDR[IDX_W+1:2];
    addr_ok   = (PADDR[1:0] == 2'b00) && (PADDR < ADDR_LIMIT);
    setup_err = !addr_ok || rd_strb_err;
    is_setup  = PSEL && !PENABLE;
    is_access = PSEL && PENABLE;
    xfer_done = (state == ST_ACCESS) && is_access && PREADY;
    wr_commit = xfer_done && cap_write && !cap_err;
    // Zero-wait reads respond at the setup edge, before the index is captured.
    rd_idx    = (state == ST_IDLE) ? setup_idx : cap_idx;
    rd_word   = regs[rd_idx];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_setup) begin
            state     <= ST_ACCESS;
            cnt       <= WAIT_LD;
            cap_idx   <= setup_idx;
            cap_write <= PWRITE;
            cap_err   <= setup_err;
            cap_wdata <= PWDATA;
            cap_strb  <= strb_in;
            if (WAIT_CYCLES == 0) begin
              PREADY  <= 1'b1;
              PSLVERR <= setup_err;
              PRDATA  <= (!PWRITE && !setup_err) ? rd_word : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            // Master dropped PSEL mid-transfer: abandon it without writing.
            state   <= ST_IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
          end else if (PENABLE) begin
            if (PREADY) begin
              state   <= ST_IDLE;
              PREADY  <= 1'b0;
              PRDATA  <= '0;
              PSLVERR <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) begin
                PREADY  <= 1'b1;
                PSLVERR <= cap_err;
                PRDATA  <= (!cap_write && !cap_err) ? rd_word : '0;
              end
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          PREADY  <= 1'b0;
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (cap_strb[b]) regs[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: a zero-wait instance (dut0) and a three-wait instance (dut3).
// Byte-strobe checks run only when APB_SLV_PSTRB_EN is defined.
module tb_apb_slave_regs;

  localparam logic [31:0] RV3 = 32'h1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, psel0, pen0, pwr0, pready0, pslverr0;
  logic [31:0] paddr0, pwdata0, prdata0;
  logic        rst3, psel3, pen3, pwr3, pready3, pslverr3;
  logic [31:0] paddr3, pwdata3, prdata3;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  pstrb0, pstrb3;
`endif

  apb_slave_regs #(.WAIT_CYCLES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst0), .PSEL(psel0), .PENABLE(pen0), .PWRITE(pwr0),
    .PADDR(paddr0), .PWDATA(pwdata0),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb0),
`endif
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0)
  );

  apb_slave_regs #(.WAIT_CYCLES(3), .RESET_VAL(RV3)) dut3 (
    .PCLK(clk), .PRESETn(rst3), .PSEL(psel3), .PENABLE(pen3), .PWRITE(pwr3),
    .PADDR(paddr3), .PWDATA(pwdata3),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb3),
`endif
    .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    string       name;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vt[10];
  logic [31:0] mdl[8];
  int          checks = 0;
  int          fails  = 0;

  function automatic logic rdy(input int d);
    return (d == 0) ? pready0 : pready3;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? prdata0 : prdata3;
  endfunction
  function automatic logic serr(input int d);
    return (d == 0) ? pslverr0 : pslverr3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input int d, input logic sel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (d == 0) begin
      psel0 = sel; pen0 = en; pwr0 = wr; paddr0 = addr; pwdata0 = data;
`ifdef APB_SLV_PSTRB_EN
      pstrb0 = strb;
`endif
    end else begin
      psel3 = sel; pen3 = en; pwr3 = wr; paddr3 = addr; pwdata3 = data;
`ifdef APB_SLV_PSTRB_EN
      pstrb3 = strb;
`endif
    end
    if (strb === 4'hx) $display("note: undefined strobe");
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
  endtask

  // One full transfer; returns just after the completing edge so a setup can follow directly.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err,
                      input string name);
    exp_t e;
    exp_t got;
    int   n;
    logic quiet;
    drive(d, 1'b1, 1'b0, wr, addr, wdata, strb);
    e.rdata = exp_rd; e.err = exp_err; e.waits = (d == 0) ? 0 : 3; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    // Address/data are deliberately disturbed in the access phase; the DUT must use captured values.
    drive(d, 1'b1, 1'b1, wr, $urandom(), $urandom(), strb);
    n = 0;
    quiet = 1'b1;
    while (!rdy(d) && n < 20) begin
      if (rdat(d) !== 32'h0 || serr(d) !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    got = sb_q.pop_front();
    if (!rdy(d)) begin
      checks++;
      fails++;
      $display("FAIL %s timeout: PREADY still %b after %0d cycles, expected 1", got.name, rdy(d), n);
    end else begin
      check({got.name, " waits"}, 32'(n), 32'(got.waits));
      check({got.name, " quiet"}, {31'h0, quiet}, 32'h1);
      if (!wr) check({got.name, " prdata"}, rdat(d), got.rdata);
      check({got.name, " pslverr"}, {31'h0, serr(d)}, {31'h0, got.err});
    end
    @(posedge clk); #1;
    check({got.name, " ready_drop"}, {31'h0, rdy(d)}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, "w04"};
    vt[1] = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, "r04"};
    vt[2] = '{1'b1, 32'h0000_0020, 32'hBAD0_BAD0, 32'h0, 1'b1, "w20_oob"};
    vt[3] = '{1'b1, 32'h0000_0006, 32'hBAD1_BAD1, 32'h0, 1'b1, "w06_misal"};
    vt[4] = '{1'b0, 32'h0000_0006, 32'h0,         32'h0, 1'b1, "r06_misal"};
    vt[5] = '{1'b1, 32'h0000_001C, 32'hCAFE_F00D, 32'h0, 1'b0, "w1c_last"};
    vt[6] = '{1'b0, 32'h0000_001C, 32'h0,         32'hCAFE_F00D, 1'b0, "r1c_last"};
    vt[7] = '{1'b0, 32'h0000_0020, 32'h0,         32'h0, 1'b1, "r20_oob"};
    vt[8] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0, 1'b0, "r00_reset"};
    vt[9] = '{1'b1, 32'h0000_0104, 32'hBAD2_BAD2, 32'h0, 1'b1, "w104_alias"};
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;

    rst0 = 1'b0; rst3 = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #12;
    check("rst pready", {31'h0, pready0}, 32'h0);
    check("rst prdata", prdata0, 32'h0);
    check("rst pslverr", {31'h0, pslverr0}, 32'h0);
    rst0 = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;

    // Table vectors on the zero-wait instance, issued back-to-back.
    for (int i = 0; i < 10; i++) begin
      xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata, 4'hF, vt[i].exp_rd, vt[i].exp_err, vt[i].name);
      if (vt[i].wr && !vt[i].exp_err) mdl[vt[i].addr[4:2]] = vt[i].wdata;
    end
    idle(0);
    for (int i = 0; i < 8; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, mdl[i], 1'b0, $sformatf("readall%0d", i));
    end
    idle(0);

    xfer(0, 1'b1, 32'h0, 32'h1111_1111, 4'hF, 32'h0, 1'b0, "b2b0 w00");
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111, 1'b0, "b2b0 r00");
    idle(0);

    // Wait-state instance: reset value, then back-to-back write/read.
    xfer(3, 1'b0, 32'h8, 32'h0, 4'h0, RV3, 1'b0, "w3 r08_reset");
    xfer(3, 1'b1, 32'h0, 32'h1111_1111, 4'hF, 32'h0, 1'b0, "b2b3 w00");
    xfer(3, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111, 1'b0, "b2b3 r00");
    xfer(3, 1'b1, 32'h20, 32'h5555_5555, 4'hF, 32'h0, 1'b1, "w3 w20_oob");
    idle(3);

    // Abort: PSEL dropped in the middle of a waited write.
    drive(3, 1'b1, 1'b0, 1'b1, 32'hC, 32'h7777_7777, 4'hF);
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b1, 32'hC, 32'h7777_7777, 4'hF);
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("abort pready", {31'h0, pready3}, 32'h0);
    xfer(3, 1'b0, 32'hC, 32'h0, 4'h0, RV3, 1'b0, "abort r0c");
    idle(3);

    // Asynchronous reset while a zero-wait write holds PREADY high.
    drive(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h9999_9999, 4'hF);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h9999_9999, 4'hF);
    check("pre-reset pready", {31'h0, pready0}, 32'h1);
    #2 rst0 = 1'b0;
    #1 check("async reset pready", {31'h0, pready0}, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 rst0 = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, "rst r10");
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0, "rst r04");
    idle(0);

`ifdef APB_SLV_PSTRB_EN
    xfer(0, 1'b1, 32'hC, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, "strb full");
    xfer(0, 1'b1, 32'hC, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, "strb 0101");
    xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, "strb r0c");
    xfer(0, 1'b0, 32'hC, 32'h0, 4'b0001, 32'h0, 1'b1, "strb rd_err");
    xfer(0, 1'b1, 32'hC, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "strb noop");
    xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, "strb r0c_after");
    idle(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
